button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 16 +
 rtl/button_conditioner_channel.sv | 60 ++++++
 rtl/button_conditioner_defs.svh | 11 +
 rtl/button_conditioner.sv | 47 ++++
 tb/tb_button_conditioner.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Typed view of the shared button constants for SystemVerilog users.
// Latency/backpressure: n/a, constants only.
package button_conditioner_pkg;

`include "button_conditioner_defs.svh"

    typedef logic [3:1] btn_t;

    localparam btn_t B1   = `BTN_B1;
    localparam btn_t B2   = `BTN_B2;
    localparam btn_t B3B1 = `BTN_B3B1;
    localparam btn_t B3B2 = `BTN_B3B2;

    localparam int DEBOUNCE_CYCLES_DEFAULT = `BTN_DEBOUNCE_CYCLES;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button bit: 2-flop synchroniser, stability counter, stable level and press pulse.
// Latency DEBOUNCE_CYCLES+2 cycles raw->clean; no backpressure (level input).
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic clean_nxt,
    output logic press
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // Any cycle agreeing with the stable level restarts the run.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign clean     = stable_q;
    assign clean_nxt = stable_d;
    assign press     = press_q;

endmodule

// File: rtl/button_conditioner_defs.svh
// Button encodings and default debounce length shared with the lab state machine.
`ifndef BUTTON_CONDITIONER_DEFS_SVH
`define BUTTON_CONDITIONER_DEFS_SVH

`define BTN_B1               3'b001
`define BTN_B2               3'b010
`define BTN_B3B1             3'b101
`define BTN_B3B2             3'b110
`define BTN_DEBOUNCE_CYCLES  16

`endif

// File: rtl/button_conditioner.sv
// Three independent debounced buttons feeding the lab state machine, plus press pulses and any-held flag.
// Latency DEBOUNCE_CYCLES+2 cycles raw->clean; no backpressure (level inputs).
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:1] b_raw,
    output logic [3:1] b_clean,
    output logic [3:1] b_press,
    output logic       b_any
);

    btn_t clean_nxt;
    logic any_q, any_d;

    for (genvar i = 1; i <= 3; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (b_raw[i]),
            .clean     (b_clean[i]),
            .clean_nxt (clean_nxt[i]),
            .press     (b_press[i])
        );
    end

    // Built from next-state so it moves in the same cycle as b_clean.
    always_comb begin
        any_d = |clean_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign b_any = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a sample-history model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int N = D + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:1] b_raw = 3'b000;
    logic [3:1] b_clean;
    logic [3:1] b_press;
    logic       b_any;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .b_raw   (b_raw),
        .b_clean (b_clean),
        .b_press (b_press),
        .b_any   (b_any)
    );

    // Model: a bit's level flips when the D raw samples taken 2..D+1 edges ago
    // all disagree with its current level; pre-reset history counts as 0.
    logic [3:1] hist[$];
    logic [3:1] m_clean = 3'b000;
    logic [3:1] m_press = 3'b000;
    logic       m_any   = 1'b0;

    always @(posedge clk) begin
        logic [3:1] prev;
        logic [3:1] smp;
        logic       flip;
        if (!rst_n) begin
            hist.delete();
            m_clean = 3'b000;
            m_press = 3'b000;
        end else begin
            prev = m_clean;
            hist.push_front(b_raw);
            for (int i = 1; i <= 3; i++) begin
                flip = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    smp = (j < hist.size()) ? hist[j] : 3'b000;
                    if (smp[i] == m_clean[i]) flip = 1'b0;
                end
                if (flip) m_clean[i] = ~m_clean[i];
            end
            m_press = m_clean & ~prev;
            while (hist.size() > D + 2) void'(hist.pop_back());
        end
        m_any = |m_clean;
    end

    logic       chk_en = 1'b0;
    logic [3:1] press_acc = 3'b000;

    always @(posedge clk) begin
        #1;
        press_acc = press_acc | b_press;
        if (chk_en) begin
            vectors++;
            if (b_clean !== m_clean || b_press !== m_press || b_any !== m_any) begin
                miscompares++;
                $display("FAIL model t=%0t: clean=%b press=%b any=%b, want clean=%b press=%b any=%b",
                         $time, b_clean, b_press, b_any, m_clean, m_press, m_any);
            end
        end
    end

    task automatic expect3(input string nm, input logic [3:1] act, input logic [3:1] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic expect1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    // Drive raw, then b_clean must hold its old value through edge N-1 and
    // take exp_clean (with pulse exp_press) after edge N.
    task automatic apply(input string nm, input logic [3:1] raw,
                         input logic [3:1] exp_clean, input logic [3:1] exp_press);
        logic [3:1] old;
        @(negedge clk);
        old   = b_clean;
        b_raw = raw;
        for (int e = 1; e < N; e++) begin
            @(posedge clk); #2;
            expect3({nm, "_hold"}, b_clean, old);
        end
        @(posedge clk); #2;
        expect3({nm, "_clean"}, b_clean, exp_clean);
        expect3({nm, "_press"}, b_press, exp_press);
        expect1({nm, "_any"}, b_any, |exp_clean);
        @(posedge clk); #2;
        expect3({nm, "_press_off"}, b_press, 3'b000);
    endtask

    task automatic pulse(input logic [3:1] mask, input int len);
        @(negedge clk);
        b_raw = mask;
        repeat (len) @(negedge clk);
        b_raw = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int         rem[3:1];
        logic [3:1] r;

        #1 rst_n = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) @(negedge clk);
        expect3("idle_clean", b_clean, 3'b000);
        expect1("idle_any", b_any, 1'b0);

        // Single press and release.
        apply("b1_press", 3'b001, 3'b001, 3'b001);
        apply("b1_release", 3'b000, 3'b000, 3'b000);

        // Short glitch never reaches the output; a 5-cycle hold does.
        @(negedge clk); press_acc = 3'b000;
        pulse(3'b010, 3);
        expect3("glitch3_clean", b_clean, 3'b000);
        expect3("glitch3_press", press_acc, 3'b000);
        pulse(3'b010, 4);
        pulse(3'b010, 5);
        expect3("hold5_press", press_acc & 3'b010, 3'b010);
        repeat (8) @(negedge clk);

        // Bounce on bit 3 then steady: 1,0,1,0 followed by a held 1.
        @(negedge clk); press_acc = 3'b000; b_raw = 3'b100;
        @(negedge clk); b_raw = 3'b000;
        @(negedge clk); b_raw = 3'b100;
        @(negedge clk); b_raw = 3'b000;
        apply("bounce", 3'b100, 3'b100, 3'b100);
        expect3("bounce_single", press_acc, 3'b100);
        apply("b3_release", 3'b000, 3'b000, 3'b000);

        // Simultaneous bits, then partial release.
        apply("b3b1", 3'b101, 3'b101, 3'b101);
        apply("b1_off", 3'b100, 3'b100, 3'b000);
        apply("all_off", 3'b000, 3'b000, 3'b000);

        // Reset in the middle of a count.
        apply("b2_on", 3'b010, 3'b010, 3'b010);
        @(negedge clk); b_raw = 3'b011;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        expect3("rst_clean", b_clean, 3'b000);
        expect3("rst_press", b_press, 3'b000);
        expect1("rst_any", b_any, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e < N; e++) begin
            @(posedge clk); #2;
            expect3("post_rst_hold", b_clean, 3'b000);
            expect3("post_rst_nopress", b_press, 3'b000);
        end
        @(posedge clk); #2;
        expect3("post_rst_clean", b_clean, 3'b011);
        expect3("post_rst_press", b_press, 3'b011);
        apply("post_rst_off", 3'b000, 3'b000, 3'b000);

        // Randomized per-bit hold lengths around the debounce threshold.
        for (int i = 1; i <= 3; i++) rem[i] = 1;
        r = 3'b000;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 1; i <= 3; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    r[i]   = ~r[i];
                    rem[i] = $urandom_range(1, D + 4);
                end
            end
            b_raw = r;
            if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
